// File: rtl/bit_exec_unit.sv
// bit_exec_unit: one-instruction-at-a-time bit-logic sequencer for a
// three-port bit RAM. Reads two operand bits, computes a result, writes it
// back (except TST) and keeps the last result as FLAG.
module bit_exec_unit #(
    parameter int unsigned AWIDTH = 2
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              START,
    input  logic [2:0]        OP,
    input  logic [AWIDTH-1:0] SRC_A,
    input  logic [AWIDTH-1:0] SRC_B,
    input  logic [AWIDTH-1:0] DST,
    output logic              BUSY,
    output logic              DONE,
    output logic              FLAG,
    output logic [AWIDTH-1:0] RAM_A_ADDRESS,
    input  logic              RAM_A_OUT,
    output logic [AWIDTH-1:0] RAM_B_ADDRESS,
    input  logic              RAM_B_OUT,
    output logic [AWIDTH-1:0] RAM_C_ADDRESS,
    output logic              RAM_C_DATA,
    output logic              RAM_C_WE
);

    localparam logic [2:0] OP_MOV  = 3'b000;
    localparam logic [2:0] OP_NOT  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_OR   = 3'b011;
    localparam logic [2:0] OP_XOR  = 3'b100;
    localparam logic [2:0] OP_NAND = 3'b101;
    localparam logic [2:0] OP_NOR  = 3'b110;
    localparam logic [2:0] OP_TST  = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_EXEC  = 2'd2,
        S_WRITE = 2'd3
    } state_t;

    state_t            state_q;
    logic [2:0]        op_q;
    logic [AWIDTH-1:0] dst_q;
    logic              opa_q;
    logic              opb_q;
    logic              result_q;
    logic              busy_q;
    logic              done_q;
    logic              flag_q;
    logic [AWIDTH-1:0] ram_a_addr_q;
    logic [AWIDTH-1:0] ram_b_addr_q;
    logic [AWIDTH-1:0] ram_c_addr_q;
    logic              ram_c_data_q;
    logic              ram_c_we_q;
    logic              exec_r_c;

    // Result of the latched opcode applied to the captured operand bits.
    always_comb begin
        exec_r_c = 1'b0;
        case (op_q)
            OP_MOV:  exec_r_c = opa_q;
            OP_NOT:  exec_r_c = ~opa_q;
            OP_AND:  exec_r_c = opa_q & opb_q;
            OP_OR:   exec_r_c = opa_q | opb_q;
            OP_XOR:  exec_r_c = opa_q ^ opb_q;
            OP_NAND: exec_r_c = ~(opa_q & opb_q);
            OP_NOR:  exec_r_c = ~(opa_q | opb_q);
            OP_TST:  exec_r_c = opa_q & opb_q;
            default: exec_r_c = 1'b0;
        endcase
    end

    // Sequencer: IDLE -> READ -> EXEC -> WRITE -> IDLE, all outputs registered.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= S_IDLE;
            op_q         <= 3'b000;
            dst_q        <= '0;
            opa_q        <= 1'b0;
            opb_q        <= 1'b0;
            result_q     <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            flag_q       <= 1'b0;
            ram_a_addr_q <= '0;
            ram_b_addr_q <= '0;
            ram_c_addr_q <= '0;
            ram_c_data_q <= 1'b0;
            ram_c_we_q   <= 1'b1;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (START) begin
                        op_q         <= OP;
                        dst_q        <= DST;
                        ram_a_addr_q <= SRC_A;
                        ram_b_addr_q <= SRC_B;
                        busy_q       <= 1'b1;
                        state_q      <= S_READ;
                    end
                end
                S_READ: begin
                    // RAM presented the data on the falling edge mid-cycle.
                    opa_q   <= RAM_A_OUT;
                    opb_q   <= RAM_B_OUT;
                    state_q <= S_EXEC;
                end
                S_EXEC: begin
                    result_q     <= exec_r_c;
                    ram_c_addr_q <= dst_q;
                    ram_c_data_q <= exec_r_c;
                    ram_c_we_q   <= (op_q == OP_TST);
                    state_q      <= S_WRITE;
                end
                S_WRITE: begin
                    flag_q     <= result_q;
                    done_q     <= 1'b1;
                    ram_c_we_q <= 1'b1;
                    busy_q     <= 1'b0;
                    state_q    <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign BUSY          = busy_q;
    assign DONE          = done_q;
    assign FLAG          = flag_q;
    assign RAM_A_ADDRESS = ram_a_addr_q;
    assign RAM_B_ADDRESS = ram_b_addr_q;
    assign RAM_C_ADDRESS = ram_c_addr_q;
    assign RAM_C_DATA    = ram_c_data_q;
    assign RAM_C_WE      = ram_c_we_q;

endmodule

// File: tb/tb_bit_exec_unit.sv
// Testbench for bit_exec_unit: behavioural falling-edge bit RAM, directed
// scenarios plus randomized instruction streams checked against a
// per-instruction reference model.
module tb_bit_exec_unit;

    localparam int unsigned AW    = 2;
    localparam int unsigned DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [2:0]    op;
    logic [AW-1:0] src_a, src_b, dst;
    logic          busy, done, flag;
    logic [AW-1:0] ram_a_addr, ram_b_addr, ram_c_addr;
    logic          ram_a_out, ram_b_out, ram_c_data, ram_c_we;

    // Behavioural bit RAM and testbench preload port.
    logic          ram [DEPTH];
    logic          pre_en;
    logic [AW-1:0] pre_addr;
    logic          pre_val;

    // Reference state
    logic          model [DEPTH];
    logic          model_flag;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    bit_exec_unit #(.AWIDTH(AW)) dut (
        .CLK(clk), .RST(rst), .START(start), .OP(op),
        .SRC_A(src_a), .SRC_B(src_b), .DST(dst),
        .BUSY(busy), .DONE(done), .FLAG(flag),
        .RAM_A_ADDRESS(ram_a_addr), .RAM_A_OUT(ram_a_out),
        .RAM_B_ADDRESS(ram_b_addr), .RAM_B_OUT(ram_b_out),
        .RAM_C_ADDRESS(ram_c_addr), .RAM_C_DATA(ram_c_data),
        .RAM_C_WE(ram_c_we)
    );

    // RAM: samples addresses and commits writes on the falling edge.
    always @(negedge clk) begin
        ram_a_out <= ram[ram_a_addr];
        ram_b_out <= ram[ram_b_addr];
        if (pre_en)         ram[pre_addr]   <= pre_val;
        else if (!ram_c_we) ram[ram_c_addr] <= ram_c_data;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic ref_op(input logic [2:0] o, input logic a, input logic b);
        case (o)
            3'd0:    return a;
            3'd1:    return ~a;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return a ^ b;
            3'd5:    return ~(a & b);
            3'd6:    return ~(a | b);
            default: return a & b;
        endcase
    endfunction

    task automatic preload(input int addr, input logic v);
        pre_en   = 1'b1;
        pre_addr = AW'(addr);
        pre_val  = v;
        tick();
        pre_en     = 1'b0;
        model[addr] = v;
    endtask

    task automatic scramble_inputs;
        op    = 3'($urandom);
        src_a = AW'($urandom);
        src_b = AW'($urandom);
        dst   = AW'($urandom);
    endtask

    // Issue one instruction in the current (idle) cycle k and check k+1..k+4.
    // Returns positioned in cycle k+4 (the DONE cycle).
    task automatic run_instr(input logic [2:0] o, input int sa, input int sb,
                             input int d, input bit noise);
        logic r;
        bit   wr;
        r  = ref_op(o, model[sa], model[sb]);
        wr = (o != 3'b111);
        op = o; src_a = AW'(sa); src_b = AW'(sb); dst = AW'(d);
        start = 1'b1;
        tick();                                   // k+1 READ
        start = noise;
        if (noise) scramble_inputs();
        chk("busy_read", busy, 1);
        chk("we_read", ram_c_we, 1);
        chk("done_read", done, 0);
        chk("a_addr", ram_a_addr, sa);
        chk("b_addr", ram_b_addr, sb);
        tick();                                   // k+2 EXEC
        if (noise) scramble_inputs();
        chk("busy_exec", busy, 1);
        chk("we_exec", ram_c_we, 1);
        tick();                                   // k+3 WRITE
        chk("busy_write", busy, 1);
        chk("we_write", ram_c_we, wr ? 0 : 1);
        if (wr) begin
            chk("c_addr", ram_c_addr, d);
            chk("c_data", ram_c_data, r);
        end
        tick();                                   // k+4 DONE
        start = 1'b0;
        chk("busy_done", busy, 0);
        chk("done", done, 1);
        if (wr) model[d] = r;
        model_flag = r;
        chk("flag", flag, model_flag);
        for (int i = 0; i < int'(DEPTH); i++) chk("ram", ram[i], model[i]);
        if (noise) begin
            tick();
            chk("noise_busy", busy, 0);
            chk("noise_done", done, 0);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b1; pre_en = 1'b0; pre_addr = '0; pre_val = 1'b0;
        op = '0; src_a = '0; src_b = '0; dst = '0;
        model_flag = 1'b0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            ram[i] = 1'b0;
            model[i] = 1'b0;
        end

        // Reset with START held: reset wins, nothing accepted.
        tick(); tick();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_flag", flag, 0);
        chk("rst_we", ram_c_we, 1);
        chk("rst_a", ram_a_addr, 0);
        chk("rst_b", ram_b_addr, 0);
        chk("rst_c", ram_c_addr, 0);
        chk("rst_cdata", ram_c_data, 0);
        rst = 1'b0; start = 1'b0;
        tick();
        chk("post_rst_busy", busy, 0);

        preload(0, 1'b1); preload(1, 1'b0); preload(2, 1'b1); preload(3, 1'b0);

        // AND 0,1 -> 2
        run_instr(3'b010, 0, 1, 2, 1'b0);
        // NOR, OR, XOR back-to-back to DST=3
        run_instr(3'b110, 0, 1, 3, 1'b0);
        run_instr(3'b011, 0, 1, 3, 1'b0);
        run_instr(3'b100, 0, 1, 3, 1'b0);
        tick();
        // TST: no write, flag set
        preload(1, 1'b1); preload(2, 1'b0);
        run_instr(3'b111, 0, 1, 2, 1'b0);
        tick();
        // NOT in place then MOV reading the freshly written bit
        preload(1, 1'b0); preload(0, 1'b0);
        run_instr(3'b001, 1, 1, 1, 1'b0);
        run_instr(3'b000, 1, 2, 0, 1'b0);
        // START pulses while busy are ignored; leaves FLAG=1
        run_instr(3'b011, 0, 3, 3, 1'b1);

        // Reset during EXEC of a MOV to DST=2 abandons the write.
        preload(2, ~model[0]);
        op = 3'b000; src_a = 2'd0; src_b = 2'd1; dst = 2'd2;
        start = 1'b1;
        tick();                                   // READ
        start = 1'b0;
        tick();                                   // EXEC
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_flag = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_flag", flag, model_flag);
        chk("abort_we", ram_c_we, 1);
        tick();
        chk("abort_we2", ram_c_we, 1);
        chk("abort_done2", done, 0);
        chk("abort_ram2", ram[2], model[2]);

        // Randomized instruction stream.
        for (int n = 0; n < 150; n++) begin
            run_instr(3'($urandom_range(0, 7)), int'($urandom_range(0, DEPTH - 1)),
                      int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, DEPTH - 1)),
                      bit'($urandom_range(0, 3) == 0));
            if ($urandom_range(0, 2) == 0) begin
                tick();
                chk("gap_busy", busy, 0);
                chk("gap_done", done, 0);
                chk("gap_flag", flag, model_flag);
                if ($urandom_range(0, 1) == 1) preload(int'($urandom_range(0, DEPTH - 1)), 1'($urandom));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
